// File: rtl/lsu_mem_pkg.sv
// Shared encodings for the LSU / data-memory path: arbiter FSM states,
// LSU handshake states and an index-width helper.
package lsu_mem_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ISSUE    = 2'd1;
    localparam logic [1:0] ST_WAIT_RSP = 2'd2;
    localparam logic [1:0] ST_RESPOND  = 2'd3;

    // Per-LSU request progress, shared by the LSU and the CU scheduler.
    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_e;

    // A single requester still needs a 1-bit index signal.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lsu_mem_arbiter_if.sv
// Bus bundle between the LSU vector, the arbiter and the data-memory controller.
// The arbiter uses the slave view; the environment (LSUs + memory) the master view.
interface lsu_mem_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_we;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_rdata;

    logic                          mem_req_valid;
    logic                          mem_req_we;
    logic [ADDR_WIDTH-1:0]         mem_req_addr;
    logic [DATA_WIDTH-1:0]         mem_req_wdata;
    logic                          mem_req_ready;
    logic                          mem_rsp_valid;
    logic [DATA_WIDTH-1:0]         mem_rsp_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        output rsp_valid, rsp_rdata,
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        input  rsp_valid, rsp_rdata,
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata
    );

endinterface

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request bit at or above start_i,
// wrapping at N.
module rr_priority_pick
    import lsu_mem_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] start_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o
);

    int            c;
    logic [IW-1:0] ci;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        c       = 0;
        ci      = '0;
        for (int i = 0; i < N; i++) begin
            // start_i is always < N, so one wrap correction suffices.
            c = int'(start_i) + i;
            if (c >= N) c = c - N;
            ci = IW'(c);
            if (!found_o && req_i[ci]) begin
                found_o = 1'b1;
                idx_o   = ci;
            end
        end
    end

endmodule

// File: rtl/lsu_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory channel among NUM_REQ LSUs;
// one transaction in flight, completion reported as a one-hot rsp_valid pulse.
module lsu_mem_arbiter
    import lsu_mem_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int ADDR_WIDTH = 8,
    parameter  int DATA_WIDTH = 8,
    localparam int IW         = idx_w(NUM_REQ)
) (
    input  logic                clk,
    input  logic                reset,
    lsu_mem_arbiter_if.slave    bus,
    output logic                busy,
    output logic [IW-1:0]       grant_idx
);

    logic [1:0]            state_q,    state_d;
    logic [IW-1:0]         rr_ptr_q,   rr_ptr_d;
    logic [IW-1:0]         grant_q,    grant_d;
    logic                  mreq_vld_q, mreq_vld_d;
    logic                  we_q,       we_d;
    logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,    wdata_d;
    logic [NUM_REQ-1:0]    rsp_vld_q,  rsp_vld_d;
    logic [DATA_WIDTH-1:0] rdata_q,    rdata_d;
    logic                  busy_q,     busy_d;

    logic                  pick_found;
    logic [IW-1:0]         pick_idx;
    int                    next_ptr;

    rr_priority_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
        .req_i   (bus.req_valid),
        .start_i (rr_ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        mreq_vld_d = mreq_vld_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rsp_vld_d  = rsp_vld_q;
        rdata_d    = rdata_q;
        busy_d     = busy_q;
        next_ptr   = int'(pick_idx) + 1;

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_d    = pick_idx;
                    we_d       = bus.req_we[pick_idx];
                    addr_d     = bus.req_addr[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d    = bus.req_wdata[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
                    mreq_vld_d = 1'b1;
                    busy_d     = 1'b1;
                    rr_ptr_d   = (next_ptr >= NUM_REQ) ? '0 : IW'(next_ptr);
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Request fields stay frozen until the controller takes them.
                if (bus.mem_req_ready) begin
                    mreq_vld_d = 1'b0;
                    state_d    = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                if (bus.mem_rsp_valid) begin
                    rdata_d            = we_q ? '0 : bus.mem_rsp_rdata;
                    rsp_vld_d          = '0;
                    rsp_vld_d[grant_q] = 1'b1;
                    state_d            = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                rsp_vld_d = '0;
                rdata_d   = '0;
                busy_d    = 1'b0;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            mreq_vld_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rsp_vld_q  <= '0;
            rdata_q    <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            mreq_vld_q <= mreq_vld_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rsp_vld_q  <= rsp_vld_d;
            rdata_q    <= rdata_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.mem_req_valid = mreq_vld_q;
    assign bus.mem_req_we    = we_q;
    assign bus.mem_req_addr  = addr_q;
    assign bus.mem_req_wdata = wdata_q;
    assign bus.rsp_valid     = rsp_vld_q;
    assign bus.rsp_rdata     = rdata_q;
    assign busy              = busy_q;
    assign grant_idx         = grant_q;

endmodule

// File: doc/lsu_mem_arbiter.md
Name: lsu_mem_arbiter

Overview:
- Shares one data-memory channel between the per-thread LSUs of a compute unit.
- Each LSU raises a load or store request. The arbiter picks one requester round-robin, runs a single memory transaction for it, and returns the result with a one-cycle response pulse.
- The arbiter sits between the LSU vector and the data-memory controller.
- Each LSU sees its request complete as its REQ→WAIT→DONE sequence advances; the CU scheduler's WAIT stage stalls until every LSU reports done.

Parameters:
- NUM_REQ, 4: number of LSU requesters; equals CU width.
- ADDR_WIDTH, 8: data-memory address width.
- DATA_WIDTH, 8: data word width.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-LSU request. Held high until that LSU sees its rsp_valid bit.
- req_we  input  NUM_REQ  per-LSU op: 1=store, 0=load.
- req_addr  input  NUM_REQ*ADDR_WIDTH  flattened addresses; slice i = [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  input  NUM_REQ*DATA_WIDTH  flattened store data.
- rsp_valid  output  NUM_REQ  one-cycle completion pulse, one-hot.
- rsp_rdata  output  DATA_WIDTH  load data; valid while rsp_valid is nonzero.
- mem_req_valid  output  1  request to memory.
- mem_req_we  output  1  store flag to memory.
- mem_req_addr  output  ADDR_WIDTH  address to memory.
- mem_req_wdata  output  DATA_WIDTH  store data to memory.
- mem_req_ready  input  1  memory accepts the request.
- mem_rsp_valid  input  1  memory response (data for loads, acknowledge for stores).
- mem_rsp_rdata  input  DATA_WIDTH  memory read data.
- busy  output  1  high in any state except IDLE.
- grant_idx  output  $clog2(NUM_REQ)  index of the requester being served.

Behaviour:
- All outputs are registered.
- Reset values: all outputs 0; state=IDLE; rr_ptr=0; internal latches 0.
- FSM states: IDLE, ISSUE, WAIT_RSP, RESPOND.
- IDLE:
  - If any req_valid bit is set, pick the first set bit searching from rr_ptr upward, wrapping at NUM_REQ.
  - Latch its index, we, addr and wdata into grant_idx and the mem_req_* registers.
  - Set mem_req_valid=1, set rr_ptr=(idx+1) mod NUM_REQ, go to ISSUE.
  - If no bit is set, stay in IDLE.
- ISSUE:
  - Hold mem_req_valid and the mem_req_* fields stable until mem_req_ready=1.
  - On that cycle, drop mem_req_valid and go to WAIT_RSP.
- WAIT_RSP:
  - On mem_rsp_valid, capture rsp_rdata: mem_rsp_rdata for a load, 0 for a store.
  - Set rsp_valid[grant_idx]=1 and go to RESPOND.
- RESPOND: clear rsp_valid and busy; go to IDLE.
  - The requester drops req_valid on the same edge, so it is never re-granted spuriously.
- Latency:
  - Request seen in IDLE at cycle 0 → mem_req_valid at cycle 1.
  - With mem_req_ready at cycle 1 and mem_rsp_valid at cycle 2, rsp_valid appears at cycle 3.
  - Total is 3 + extra ready stall cycles + extra memory latency.
- Exactly one transaction is outstanding at any time; no pipelining.
- Boundary conditions:
  - mem_rsp_valid during IDLE or ISSUE is ignored. The memory contract forbids a same-cycle response.
  - A requester deasserting req_valid mid-transaction does not abort it; the rsp_valid pulse still fires.
  - Simultaneous requests from all LSUs are served in rr_ptr order, each exactly once per rotation. There is no starvation.
  - Reset mid-transaction returns to IDLE with mem_req_valid=0 on the next cycle. A late mem_rsp_valid arriving in IDLE is dropped.
  - rr_ptr wraps from NUM_REQ-1 to 0.
  - With NUM_REQ=1 the arbiter degenerates to a pass-through sequencer; rr_ptr stays 0.

Decomposition:
- Shared package lsu_mem_pkg holds:
  - state encodings (IDLE=0, ISSUE=1, WAIT_RSP=2, RESPOND=3);
  - LSU state encodings (LSU_IDLE/REQ/WAIT/DONE) reused by the LSU and the scheduler.
- One combinational sub-module, rr_priority_pick. Inputs: req vector and start pointer. Outputs: found flag and index.

Test Plan:
- Single load: LSU 2 requests addr 0x10, memory ready immediately, rdata 0xAB at latency 1 → mem_req_addr=0x10 at cycle 1; rsp_valid=4'b0100 with rsp_rdata=0xAB at cycle 3; busy=0 at cycle 4.
- Store with ready stall: LSU 0 stores 0x5A to 0x22, mem_req_ready low for 3 cycles → request fields held stable; rsp_valid=4'b0001 with rsp_rdata=0.
- All four LSUs request at once, from reset → grants in order 0,1,2,3; four rsp_valid pulses; rr_ptr ends at 0.
- Fairness: LSU 3 is served, then LSUs 0 and 3 re-request → LSU 0 is granted before LSU 3.
- Reset during WAIT_RSP, then mem_rsp_valid pulses → no rsp_valid; state IDLE; all outputs 0.
- Requester drops req_valid during ISSUE → transaction completes and its rsp_valid bit still pulses once.
